// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: SHL/SHR/SAR/ROL/ROR/RCL/RCR with start/busy/done handshake.
// Processes up to STEP single-bit steps per cycle through a chained step network.
module seq_shift_unit #(
    parameter int WIDTH      = 16,
    parameter int STEP       = 1,
    parameter int MASK_COUNT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       op,
    input  logic             is_8_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       count,
    input  logic [15:0]      flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [15:0]      flags_out
);

    localparam int CF_IDX = 0;
    localparam int PF_IDX = 2;
    localparam int ZF_IDX = 6;
    localparam int SF_IDX = 7;
    localparam int OF_IDX = 11;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_RCL = 3'd5;
    localparam logic [2:0] OP_RCR = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam int IDX_W = $clog2(WIDTH);
    // The remaining-count register is 8 bits, so a STEP above 255 always finishes in one cycle.
    localparam int         STEP_SAT = (STEP > 255) ? 255 : STEP;
    localparam logic [7:0] STEP_L   = STEP_SAT[7:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic             byte_q;
    logic [WIDTH-1:0] val_q;
    logic             cf_q;
    logic [7:0]       rem_q;
    logic [15:0]      flags_q;
    logic             msb0_q;
    logic [WIDTH-1:0] result_q;
    logic [15:0]      flags_out_q;

    // One single-bit step; returns {carry, value}. Byte mode keeps bits above 7 at zero.
    function automatic logic [WIDTH:0] step_bit(input logic [WIDTH-1:0] v, input logic c,
                                                input logic [2:0] o, input logic b);
        logic [IDX_W-1:0] top;
        logic             msb;
        logic [WIDTH-1:0] sl;
        logic [WIDTH-1:0] sr;
        logic [WIDTH-1:0] r;
        logic             nc;
        top = b ? IDX_W'(7) : IDX_W'(WIDTH - 1);
        msb = v[top];
        sl  = v << 1;
        if (b) sl[WIDTH-1:8] = '0;
        sr  = v >> 1;
        r   = v;
        nc  = c;
        case (o)
            OP_SHL: begin r = sl; nc = msb; end
            OP_SHR: begin r = sr; nc = v[0]; end
            OP_SAR: begin r = sr; r[top] = msb; nc = v[0]; end
            OP_ROL: begin r = sl; r[0] = msb; nc = msb; end
            OP_ROR: begin r = sr; r[top] = v[0]; nc = v[0]; end
            OP_RCL: begin r = sl; r[0] = c; nc = msb; end
            OP_RCR: begin r = sr; r[top] = c; nc = v[0]; end
            default: ;
        endcase
        return {nc, r};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_stage
            logic [WIDTH-1:0] v_in;
            logic             c_in;
            logic [WIDTH:0]   stepped;
            logic             act;
            logic [WIDTH-1:0] v_out;
            logic             c_out;
            if (gi == 0) begin : g_first
                assign v_in = val_q;
                assign c_in = cf_q;
            end else begin : g_next
                assign v_in = g_stage[gi-1].v_out;
                assign c_in = g_stage[gi-1].c_out;
            end
            if (gi < 255) begin : g_act
                assign act = (rem_q > 8'(gi));
            end else begin : g_never
                assign act = 1'b0;
            end
            assign stepped = step_bit(v_in, c_in, op_q, byte_q);
            assign v_out   = act ? stepped[WIDTH-1:0] : v_in;
            assign c_out   = act ? stepped[WIDTH] : c_in;
        end
    endgenerate

    logic [WIDTH-1:0] fin_val;
    logic             fin_cf;
    logic             fin_msb;
    logic             fin_msb1;
    logic             rem_last;
    logic [15:0]      flags_fin;
    logic [7:0]       n_eff;
    logic [WIDTH-1:0] operand;

    assign fin_val  = g_stage[STEP-1].v_out;
    assign fin_cf   = g_stage[STEP-1].c_out;
    assign fin_msb  = byte_q ? fin_val[7] : fin_val[WIDTH-1];
    assign fin_msb1 = byte_q ? fin_val[6] : fin_val[WIDTH-2];
    assign rem_last = (rem_q <= STEP_L);
    assign operand  = is_8_bit ? {{(WIDTH-8){1'b0}}, a[7:0]} : a;

    always_comb begin
        n_eff = '0;
        if (op != OP_RSV) n_eff = (MASK_COUNT != 0) ? (count & 8'h1f) : count;
    end

    always_comb begin
        flags_fin         = flags_q;
        flags_fin[CF_IDX] = fin_cf;
        case (op_q)
            OP_SHL, OP_ROL, OP_RCL: flags_fin[OF_IDX] = fin_msb ^ fin_cf;
            OP_SHR:                 flags_fin[OF_IDX] = msb0_q;
            OP_SAR:                 flags_fin[OF_IDX] = 1'b0;
            default:                flags_fin[OF_IDX] = fin_msb ^ fin_msb1;
        endcase
        // Rotates leave the result-derived flags alone.
        if (op_q == OP_SHL || op_q == OP_SHR || op_q == OP_SAR) begin
            flags_fin[SF_IDX] = fin_msb;
            flags_fin[ZF_IDX] = (fin_val == '0);
            flags_fin[PF_IDX] = ~^fin_val[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (n_eff == 8'd0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort)         state_d = S_IDLE;
                else if (rem_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q        <= '0;
            byte_q      <= 1'b0;
            val_q       <= '0;
            cf_q        <= 1'b0;
            rem_q       <= '0;
            flags_q     <= '0;
            msb0_q      <= 1'b0;
            result_q    <= '0;
            flags_out_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        byte_q  <= is_8_bit;
                        val_q   <= operand;
                        cf_q    <= flags_in[CF_IDX];
                        rem_q   <= n_eff;
                        flags_q <= flags_in;
                        msb0_q  <= is_8_bit ? a[7] : a[WIDTH-1];
                        if (n_eff == 8'd0) begin
                            result_q    <= operand;
                            flags_out_q <= flags_in;
                        end
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        val_q <= fin_val;
                        cf_q  <= fin_cf;
                        rem_q <= rem_last ? 8'd0 : (rem_q - STEP_L);
                        if (rem_last) begin
                            result_q    <= fin_val;
                            flags_out_q <= flags_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign flags_out = flags_out_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: three instances (STEP=1 masked, STEP=4 masked, STEP=1 unmasked)
// share the input bus; each scenario task checks one instance against hand-computed values.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [2:0]  op;
    logic        is_8_bit;
    logic [15:0] a;
    logic [7:0]  count;
    logic [15:0] flags_in;

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [15:0] result0, result1, result2;
    logic [15:0] flags0, flags1, flags2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(16), .STEP(1), .MASK_COUNT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op), .is_8_bit(is_8_bit),
        .a(a), .count(count), .flags_in(flags_in),
        .busy(busy0), .done(done0), .result(result0), .flags_out(flags0));

    seq_shift_unit #(.WIDTH(16), .STEP(4), .MASK_COUNT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op), .is_8_bit(is_8_bit),
        .a(a), .count(count), .flags_in(flags_in),
        .busy(busy1), .done(done1), .result(result1), .flags_out(flags1));

    seq_shift_unit #(.WIDTH(16), .STEP(1), .MASK_COUNT(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op), .is_8_bit(is_8_bit),
        .a(a), .count(count), .flags_in(flags_in),
        .busy(busy2), .done(done2), .result(result2), .flags_out(flags2));

    typedef struct {
        int          sel;
        logic [2:0]  o;
        logic        b;
        logic [15:0] av;
        logic [7:0]  cv;
        logic [15:0] fv;
        int          lat;
        logic [15:0] res;
        logic [15:0] fl;
    } vec_t;

    function automatic logic get_done(input int s);
        case (s)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [15:0] get_res(input int s);
        case (s)
            0:       return result0;
            1:       return result1;
            default: return result2;
        endcase
    endfunction

    function automatic logic [15:0] get_fl(input int s);
        case (s)
            0:       return flags0;
            1:       return flags1;
            default: return flags2;
        endcase
    endfunction

    task automatic wait_idle();
        int c = 0;
        while ((busy0 | done0 | busy1 | done1 | busy2 | done2) && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (c >= 300) begin
            vectors++;
            errors++;
            $display("FAIL wait_idle: units still active after %0d cycles, required idle", c);
        end
    endtask

    // Launch one operation, scramble the inputs after the start cycle, and wait for done.
    task automatic run_op(input int sel, input logic [2:0] o, input logic b, input logic [15:0] av,
                          input logic [7:0] cv, input logic [15:0] fv,
                          output int lat, output int busy_cyc,
                          output logic [15:0] res, output logic [15:0] fl);
        @(negedge clk);
        op = o; is_8_bit = b; a = av; count = cv; flags_in = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; count = ~cv; op = o ^ 3'd1; flags_in = ~fv; is_8_bit = ~b;
        lat = 1;
        busy_cyc = 0;
        while (!get_done(sel) && lat < 200) begin
            if (get_busy(sel)) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        res = get_res(sel);
        fl  = get_fl(sel);
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; abort = 1'b0; op = 3'd0; is_8_bit = 1'b0;
        a = 16'h1234; count = 8'd1; flags_in = 16'hFFFF;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        vectors++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
        vectors++;
        if (result0 !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result0); end
        vectors++;
        if (flags0 !== 16'h0000) begin errors++; $display("FAIL reset_flags: got %h want 0000", flags0); end
        start = 1'b0;
        reset = 1'b1;
        $display("reset: busy=%b done=%b result=%h flags=%h", busy0, done0, result0, flags0);
    endtask

    task automatic test_shift_rotate();
        vec_t vecs[$];
        int lat, bc;
        logic [15:0] res, fl;
        vecs.push_back('{0, 3'd0, 1'b0, 16'h8001, 8'h01, 16'h0000,  2, 16'h0002, 16'h0801});
        vecs.push_back('{0, 3'd5, 1'b1, 16'h0080, 8'h21, 16'h00C4,  2, 16'h0000, 16'h08C5});
        vecs.push_back('{2, 3'd5, 1'b1, 16'h0080, 8'h21, 16'h00C4, 34, 16'h0010, 16'h00C4});
        vecs.push_back('{0, 3'd4, 1'b0, 16'h1234, 8'h00, 16'h0801,  1, 16'h1234, 16'h0801});
        vecs.push_back('{0, 3'd7, 1'b0, 16'hBEEF, 8'h05, 16'h0044,  1, 16'hBEEF, 16'h0044});
        vecs.push_back('{0, 3'd1, 1'b0, 16'h00FF, 8'h14, 16'h0000, 21, 16'h0000, 16'h0044});
        vecs.push_back('{0, 3'd3, 1'b0, 16'h8001, 8'h01, 16'h0000,  2, 16'h0003, 16'h0801});
        vecs.push_back('{0, 3'd4, 1'b0, 16'h0001, 8'h01, 16'h0000,  2, 16'h8000, 16'h0801});
        vecs.push_back('{0, 3'd6, 1'b1, 16'h0001, 8'h01, 16'h0001,  2, 16'h0080, 16'h0801});
        vecs.push_back('{0, 3'd1, 1'b1, 16'hAB81, 8'h01, 16'h0000,  2, 16'h0040, 16'h0801});
        vecs.push_back('{0, 3'd2, 1'b1, 16'h0080, 8'h09, 16'h0000, 10, 16'h00FF, 16'h0085});
        vecs.push_back('{0, 3'd0, 1'b0, 16'h0001, 8'h10, 16'h0000, 17, 16'h0000, 16'h0845});
        vecs.push_back('{0, 3'd0, 1'b0, 16'h0003, 8'h11, 16'h0000, 18, 16'h0000, 16'h0044});
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].o, vecs[i].b, vecs[i].av, vecs[i].cv, vecs[i].fv,
                   lat, bc, res, fl);
            $display("vec %0d: unit=%0d op=%0d byte=%b a=%h count=%h -> lat=%0d result=%h flags=%h",
                     i, vecs[i].sel, vecs[i].o, vecs[i].b, vecs[i].av, vecs[i].cv, lat, res, fl);
            vectors++;
            if (lat != vecs[i].lat) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vecs[i].lat);
            end
            vectors++;
            if (res !== vecs[i].res) begin
                errors++;
                $display("FAIL vec%0d_result: got %h want %h", i, res, vecs[i].res);
            end
            vectors++;
            if (fl !== vecs[i].fl) begin
                errors++;
                $display("FAIL vec%0d_flags: got %h want %h", i, fl, vecs[i].fl);
            end
        end
    endtask

    task automatic test_step4();
        int lat, bc;
        logic [15:0] res, fl;
        run_op(1, 3'd2, 1'b0, 16'h8000, 8'd7, 16'h0000, lat, bc, res, fl);
        $display("step4 SAR: lat=%0d busy_cycles=%0d result=%h flags=%h", lat, bc, res, fl);
        vectors++;
        if (lat != 3) begin errors++; $display("FAIL step4_latency: got %0d want 3", lat); end
        vectors++;
        if (bc != 2) begin errors++; $display("FAIL step4_busy_cycles: got %0d want 2", bc); end
        vectors++;
        if (res !== 16'hFF00) begin errors++; $display("FAIL step4_result: got %h want ff00", res); end
        vectors++;
        if (fl !== 16'h0084) begin errors++; $display("FAIL step4_flags: got %h want 0084", fl); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int lat = 0;
        logic [15:0] res = 16'h0000;
        @(negedge clk);
        op = 3'd0; is_8_bit = 1'b0; a = 16'h0001; count = 8'd3; flags_in = 16'h0000; start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            a = 16'hFFFF;
            count = 8'd7;
            if (done0) begin
                pulses++;
                if (lat == 0) begin
                    lat = cyc;
                    res = result0;
                end
                start = 1'b0;
            end
        end
        start = 1'b0;
        $display("back_to_back: done_pulses=%0d lat=%0d result=%h", pulses, lat, res);
        vectors++;
        if (pulses != 1) begin errors++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
        vectors++;
        if (lat != 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
        vectors++;
        if (res !== 16'h0008) begin errors++; $display("FAIL b2b_result: got %h want 0008", res); end
        wait_idle();
    endtask

    task automatic test_abort();
        int pulses = 0;
        @(negedge clk);
        op = 3'd0; is_8_bit = 1'b0; a = 16'h00F0; count = 8'd10; flags_in = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy0); end
        vectors++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done_now: got %b want 0", done0); end
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done0) pulses++;
        end
        $display("abort: later done pulses=%0d result=%h flags=%h", pulses, result0, flags0);
        vectors++;
        if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
        vectors++;
        if (result0 !== 16'h0008) begin errors++; $display("FAIL abort_result_kept: got %h want 0008", result0); end
        vectors++;
        if (flags0 !== 16'h0000) begin errors++; $display("FAIL abort_flags_kept: got %h want 0000", flags0); end
        wait_idle();
    endtask

    task automatic test_reset_midrun();
        int lat, bc;
        logic [15:0] res, fl;
        @(negedge clk);
        op = 3'd0; is_8_bit = 1'b0; a = 16'h0001; count = 8'd10; flags_in = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("reset_midrun: busy=%b done=%b result=%h flags=%h", busy0, done0, result0, flags0);
        vectors++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy0); end
        vectors++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done0); end
        vectors++;
        if (result0 !== 16'h0000) begin errors++; $display("FAIL rmid_result: got %h want 0000", result0); end
        vectors++;
        if (flags0 !== 16'h0000) begin errors++; $display("FAIL rmid_flags: got %h want 0000", flags0); end
        wait_idle();
        run_op(0, 3'd0, 1'b0, 16'h0001, 8'd10, 16'h0000, lat, bc, res, fl);
        $display("fresh SHL after reset: lat=%0d result=%h flags=%h", lat, res, fl);
        vectors++;
        if (lat != 11) begin errors++; $display("FAIL rmid_fresh_latency: got %0d want 11", lat); end
        vectors++;
        if (res !== 16'h0400) begin errors++; $display("FAIL rmid_fresh_result: got %h want 0400", res); end
        vectors++;
        if (fl !== 16'h0004) begin errors++; $display("FAIL rmid_fresh_flags: got %h want 0004", fl); end
    endtask

    initial begin
        test_reset();
        test_shift_rotate();
        test_step4();
        test_back_to_back();
        test_abort();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
